bcsa_vl_adder: RTL and testbench



---
 rtl/bcsa_pkg.sv | 16 +
 rtl/bcsa_spec_core.sv | 73 +++++++
 rtl/bcsa_vl_adder.sv | 137 +++++++++++++
 tb/tb_bcsa_vl_adder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcsa_pkg.sv
// Shared definitions for the variable-latency block carry-speculative adder:
// per-transaction mode encoding and the control FSM state type.
package bcsa_pkg;

  // Mode is captured with the operands; any value >= MODE_EXACT means exact.
  localparam logic [1:0] MODE_APPROX  = 2'd0;
  localparam logic [1:0] MODE_CORRECT = 2'd1;
  localparam logic [1:0] MODE_EXACT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } bcsa_state_e;

endpackage

// File: rtl/bcsa_spec_core.sv
// Combinational carry-speculative adder core.
// Each inter-block carry is guessed from the top bit of the lower block and a
// BLK-bit window below the boundary; each block then ripples its own carries
// from that guess. The core also flags, per block, whether its slice of the
// fast result disagrees with a reference exact sum supplied by the caller.
module bcsa_spec_core #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH:0]       exact,
  output logic [WIDTH:0]       sum,
  output logic [WIDTH/BLK-1:0] blk_miss
);

  localparam int NB = WIDTH / BLK;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [NB-1:0]    cblk;

  assign p = a ^ b;
  assign g = a & b;

  // Block 0 always starts from a zero carry.
  assign cblk[0] = 1'b0;

  // Speculated carry into each block k >= 1.
  for (genvar k = 1; k < NB; k++) begin : g_spec
    localparam int J = k * BLK;
    logic [BLK:0] cw;
    logic         sel;

    // Window carry-in: generate bit just below the window, none for block 1.
    if (k >= 2) begin : g_wcin
      assign cw[0] = g[J-BLK-1];
    end else begin : g_wcin0
      assign cw[0] = 1'b0;
    end

    for (genvar i = 0; i < BLK; i++) begin : g_win
      assign cw[i+1] = g[J-BLK+i] | (p[J-BLK+i] & cw[i]);
    end

    // When the boundary is decided locally, trust g[J-1]; else use the window.
    assign sel     = g[J-1] | (~a[J] & ~b[J]);
    assign cblk[k] = sel ? g[J-1] : cw[BLK];
  end

  // Per-block sums rippled from the speculated block carry-in.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int L = k * BLK;
    logic [BLK-1:0] c;

    assign c[0] = cblk[k];
    for (genvar i = 1; i < BLK; i++) begin : g_rc
      assign c[i] = g[L+i-1] | (p[L+i-1] & c[i-1]);
    end
    for (genvar i = 0; i < BLK; i++) begin : g_s
      assign sum[L+i] = p[L+i] ^ c[i];
    end

    // The top block also owns the carry-out and compares it.
    if (k == NB - 1) begin : g_top
      assign sum[WIDTH]  = g[WIDTH-1] | (p[WIDTH-1] & c[BLK-1]);
      assign blk_miss[k] = |(sum[WIDTH:L] ^ exact[WIDTH:L]);
    end else begin : g_mid
      assign blk_miss[k] = |(sum[L+BLK-1:L] ^ exact[L+BLK-1:L]);
    end
  end

endmodule

// File: rtl/bcsa_vl_adder.sv
// Registered variable-latency carry-speculative adder stage.
// Handshake: a transfer happens on a port in any cycle where valid and ready
// are both 1 at the rising edge; a producer holding valid=1 keeps its data
// stable until the transfer, and out_sum/out_err stay stable while
// out_valid=1 and out_ready=0.
// Fast results (APPROX, or CORRECT with no speculation error) are offered one
// cycle after acceptance; EXACT and corrected results take two cycles, the
// exact adder being a two-cycle path from the held operand registers.
module bcsa_vl_adder
  import bcsa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr,
  output bcsa_state_e      dbg_state
);

  localparam int NB = WIDTH / BLK;

  bcsa_state_e      state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       mode_q;
  logic [WIDTH:0]   approx_sum;
  logic [WIDTH:0]   exact_sum;
  logic [NB-1:0]    blk_miss;
  logic             spec_err;
  logic             is_approx, is_correct, fast;
  logic             ready_c, load, out_hs, cnt_inc;

  assign exact_sum = {1'b0, a_q} + {1'b0, b_q};

  bcsa_spec_core #(
    .WIDTH (WIDTH),
    .BLK   (BLK)
  ) u_core (
    .a        (a_q),
    .b        (b_q),
    .exact    (exact_sum),
    .sum      (approx_sum),
    .blk_miss (blk_miss)
  );

  assign spec_err   = |blk_miss;
  assign is_approx  = (mode_q == MODE_APPROX);
  assign is_correct = (mode_q == MODE_CORRECT);
  assign fast       = (mode_q < MODE_EXACT) && !(is_correct && spec_err);
  assign in_ready   = ready_c & rst_n;
  assign out_hs     = out_valid & out_ready;
  assign cnt_inc    = out_hs & (mode_q < MODE_EXACT) & spec_err;
  assign dbg_state  = state;

  // Next state, handshake signals and result selection.
  always_comb begin
    state_nx  = state;
    ready_c   = 1'b0;
    load      = 1'b0;
    out_valid = 1'b0;
    out_sum   = approx_sum;
    out_err   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          state_nx = EVAL;
        end
      end
      EVAL: begin
        if (fast) begin
          out_valid = 1'b1;
          out_err   = is_approx & spec_err;
          ready_c   = out_ready;
          if (out_ready) begin
            load     = in_valid;
            state_nx = in_valid ? EVAL : IDLE;
          end
        end else begin
          state_nx = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        out_sum   = exact_sum;
        out_err   = is_correct;
        ready_c   = out_ready;
        if (out_ready) begin
          load     = in_valid;
          state_nx = in_valid ? EVAL : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and operand registers; operands only change on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_APPROX;
    end else begin
      state <= state_nx;
      if (load) begin
        a_q    <= in_a;
        b_q    <= in_b;
        mode_q <= in_mode;
      end
    end
  end

  // Saturating speculation-error counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (cnt_inc && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcsa_vl_adder.sv
// Bench for bcsa_vl_adder: directed scenarios plus randomized transactions
// against a block-arithmetic reference of the speculative adder.
module tb_bcsa_vl_adder;
  import bcsa_pkg::*;

  localparam int W  = 32;
  localparam int B  = 4;
  localparam int CW = 4;
  localparam int NB = W / B;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_a      = '0;
  logic [W-1:0]    in_b      = '0;
  logic [1:0]      in_mode   = 2'd0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W:0]      out_sum;
  logic            out_err;
  logic [CW-1:0]   err_cnt;
  logic            cnt_clr   = 1'b0;
  bcsa_state_e     dbg_state;

  int n_checks  = 0;
  int n_err     = 0;
  int model_cnt = 0;
  logic [W+1:0] exp_q[$];
  logic [W:0]   last_sum;
  logic         last_err;

  bcsa_vl_adder #(.WIDTH(W), .BLK(B), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .cnt_clr   (cnt_clr),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: each block is a plain BLK-bit addition with a guessed carry-in.
  function automatic logic [W:0] approx_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]      r;
    logic [W:0]      blkv;
    longint unsigned m, sa, sb, s, cadd, ci;
    logic            c, gb;
    int              j;
    m = (64'd1 << B) - 1;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      j = k * B;
      c = 1'b0;
      if (k > 0) begin
        gb = a[j-1] & b[j-1];
        ci = 0;
        if (k >= 2) ci = longint'(a[j-B-1] & b[j-B-1]);
        sa   = (longint'(a) >> (j - B)) & m;
        sb   = (longint'(b) >> (j - B)) & m;
        cadd = (sa + sb + ci) >> B;
        if (gb || (!a[j] && !b[j])) c = gb;
        else c = cadd[0];
      end
      s    = ((longint'(a) >> j) & m) + ((longint'(b) >> j) & m) + longint'(c);
      blkv = (W+1)'(s & m);
      r    = r | (blkv << j);
      if (k == NB - 1) r[W] = s[B];
    end
    return r;
  endfunction

  function automatic logic [W:0] exact_model(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counter model applied at each output handshake.
  task automatic model_hs(input logic [1:0] mode, input logic spec, input bit clr);
    if (clr) model_cnt = 0;
    else if (mode < 2 && spec && model_cnt < (1 << CW) - 1) model_cnt++;
  endtask

  // Driver: one full transaction with an optional consumer stall.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                        input int stall, input bit clr);
    logic [W:0]   ap, ex, e_sum;
    logic         spec, e_err;
    logic [W+1:0] exp_v;
    int           lat, n;
    ap   = approx_model(a, b);
    ex   = exact_model(a, b);
    spec = (ap != ex);
    if (mode == 2'd0) begin
      e_sum = ap; e_err = spec; lat = 1;
    end else if (mode == 2'd1) begin
      e_sum = spec ? ex : ap; e_err = spec; lat = spec ? 2 : 1;
    end else begin
      e_sum = ex; e_err = 1'b0; lat = 2;
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({e_err, e_sum});
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_mode = 2'($urandom_range(0, 3));
    @(negedge clk);
    n = 1;
    if (lat == 2) chk("slow_in_ready", 64'(in_ready), 64'd0);
    while (!out_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    exp_v = exp_q.pop_front();
    chk("sum", 64'(out_sum), 64'(exp_v[W:0]));
    chk("err", 64'(out_err), 64'(exp_v[W+1]));
    last_sum = out_sum;
    last_err = out_err;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = $urandom;
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(out_sum), 64'(exp_v[W:0]));
      chk("stall_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    cnt_clr   = clr;
    out_ready = 1'b1;
    @(posedge clk);
    model_hs(mode, spec, clr);
    #1;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    @(negedge clk);
    chk("err_cnt", 64'(err_cnt), 64'(model_cnt));
    chk("drained", 64'(out_valid), 64'd0);
  endtask

  // Stimulus sequence
  initial begin
    logic [W:0]   ap79;
    logic         sp79;
    logic [W-1:0] ra, rb;
    int           pat;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Speculation miss on the block-0/1 boundary
    do_txn(32'h0000000F, 32'h00000001, 2'd0, 0, 1'b0);
    chk("approx_f1_sum", 64'(last_sum), 64'h0);
    chk("approx_f1_err", 64'(last_err), 64'd1);
    chk("approx_f1_cnt", 64'(err_cnt), 64'd1);
    do_txn(32'h0000000F, 32'h00000001, 2'd1, 1, 1'b0);
    chk("corr_f1_sum", 64'(last_sum), 64'h10);
    chk("corr_f1_err", 64'(last_err), 64'd1);
    chk("corr_f1_cnt", 64'(err_cnt), 64'd2);
    do_txn(32'hFFFFFFFF, 32'h00000001, 2'd0, 0, 1'b0);
    chk("approx_ff_sum", 64'(last_sum), 64'h0FFFFFF00);
    chk("approx_ff_err", 64'(last_err), 64'd1);
    do_txn(32'hFFFFFFFF, 32'h00000001, 2'd2, 2, 1'b0);
    chk("exact_ff_sum", 64'(last_sum), 64'h100000000);
    chk("exact_ff_err", 64'(last_err), 64'd0);
    chk("exact_ff_cnt", 64'(err_cnt), 64'd3);
    do_txn(32'h12345678, 32'h0000FFFF, 2'd3, 0, 1'b0);

    // Back-to-back fast transactions, then a held result
    ap79 = approx_model(32'h7, 32'h9);
    sp79 = (ap79 != exact_model(32'h7, 32'h9));
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h3; in_b = 32'h5; in_mode = 2'd0; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready0", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_a = 32'h7; in_b = 32'h9;
    @(negedge clk);
    chk("b2b_valid0", 64'(out_valid), 64'd1);
    chk("b2b_sum0", 64'(out_sum), 64'h8);
    chk("b2b_err0", 64'(out_err), 64'd0);
    chk("b2b_ready1", 64'(in_ready), 64'd1);
    @(posedge clk);
    model_hs(2'd0, 1'b0, 1'b0);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    chk("b2b_sum1", 64'(out_sum), 64'(ap79));
    chk("b2b_err1", 64'(out_err), 64'(sp79));
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      chk("b2b_hold_sum", 64'(out_sum), 64'(ap79));
      chk("b2b_hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    model_hs(2'd0, sp79, 1'b0);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_cnt", 64'(err_cnt), 64'(model_cnt));
    chk("b2b_idle", 64'(out_valid), 64'd0);

    // Saturation and clear priority
    for (int i = 0; i < 16; i++) do_txn(32'h0000000F, 32'h00000001, 2'd0, 0, 1'b0);
    chk("sat_cnt", 64'(err_cnt), 64'hF);
    do_txn(32'h0000000F, 32'h00000001, 2'd0, 0, 1'b1);
    chk("clr_cnt", 64'(err_cnt), 64'h0);

    // Reset during the slow CORRECT cycle
    do_txn(32'h0000000F, 32'h00000001, 2'd0, 0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h0000000F; in_b = 32'h00000001; in_mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_slow_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_sum", 64'(out_sum), 64'd0);
    model_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    chk("mid_rel_valid", 64'(out_valid), 64'd0);

    // Randomized transactions
    for (int t = 0; t < 160; t++) begin
      pat = $urandom_range(0, 3);
      ra  = $urandom;
      rb  = $urandom;
      case (pat)
        1: begin ra = ra & 32'h0F0F0F0F; rb = rb & 32'h0F0F0F0F; end
        2: rb = ~ra + 32'($urandom_range(0, 20));
        3: begin ra = ra | 32'hF0F0F0F0; rb = 32'($urandom_range(0, 255)); end
        default: ;
      endcase
      do_txn(ra, rb, 2'($urandom_range(0, 3)), $urandom_range(0, 2), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
